// File: rtl/pid_controller_pl_if.sv
// Sample/result bundle between the sampling logic, the PID block and the actuator stage.
// Latency: none (wires only).
// Backpressure: sample_ready from the slave qualifies sample_valid; results are not backpressured.
interface pid_controller_pl_if #(
  parameter int W  = 8,
  parameter int GW = 8
) ();
  logic          sample_valid;
  logic          sample_ready;
  logic [W-1:0]  setpoint;
  logic [W-1:0]  feedback;
  logic [GW-1:0] kp;
  logic [GW-1:0] ki;
  logic [GW-1:0] kd;
  logic          int_clear;
  logic          out_valid;
  logic [W-1:0]  control_out;

  modport master (
    output sample_valid, setpoint, feedback, kp, ki, kd, int_clear,
    input  sample_ready, out_valid, control_out
  );

  modport slave (
    input  sample_valid, setpoint, feedback, kp, ki, kd, int_clear,
    output sample_ready, out_valid, control_out
  );
endinterface

// File: rtl/pid_controller_pl.sv
// PID controller with one time-shared multiplier, saturating integral and derivative term.
// Latency: out_valid pulses in the cycle after the 5th rising edge following the accept edge.
// Backpressure: sample_ready is high only when idle; offers made while busy are ignored.
module pid_controller_pl #(
  parameter int W       = 8,
  parameter int GW      = 8,
  parameter int FRAC    = 4,
  parameter int ACCW    = 24,
  parameter int INT_LIM = 4095
) (
  input logic              clk,
  input logic              rst_n,
  pid_controller_pl_if.slave bus
);
  // Full product width of an unsigned gain times a signed (W+2)-bit operand.
  localparam int PW = GW + W + 3;

  localparam logic signed [ACCW:0]   LIM_P = (ACCW+1)'(INT_LIM);
  localparam logic signed [ACCW:0]   LIM_N = -LIM_P;
  localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((1 << W) - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_MP   = 3'd2,
    S_MI   = 3'd3,
    S_MD   = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic sample_ready;
  logic ld_sample, do_err, do_mp, do_mi, do_md, do_out;

  logic [W-1:0]           sp_q, fb_q;
  logic [GW-1:0]          kp_q, ki_q, kd_q;
  logic signed [W:0]      err_q, prev_err_q;
  logic signed [W+1:0]    de_q;
  logic                   have_prev_q;
  logic signed [ACCW-1:0] integral_q, acc_q;
  logic                   out_valid_q;
  logic [W-1:0]           control_out_q, control_out_d;

  logic signed [W:0]      err_calc;
  logic signed [W+1:0]    de_calc;
  logic                   hp_eff;
  logic [GW-1:0]          mul_gain;
  logic signed [W+1:0]    mul_opnd;
  logic signed [PW-1:0]   mul_a, mul_b, prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW:0]   int_sum;
  logic signed [ACCW-1:0] int_clamped, int_new;
  logic signed [ACCW-1:0] y;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: fixed walk through the multiply phases once a sample is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.sample_valid) state_d = S_ERR;
      S_ERR:   state_d = S_MP;
      S_MP:    state_d = S_MI;
      S_MI:    state_d = S_MD;
      S_MD:    state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: handshake and per-phase datapath enables
  always_comb begin
    sample_ready = 1'b0;
    ld_sample    = 1'b0;
    do_err       = 1'b0;
    do_mp        = 1'b0;
    do_mi        = 1'b0;
    do_md        = 1'b0;
    do_out       = 1'b0;
    case (state_q)
      S_IDLE: begin
        sample_ready = 1'b1;
        ld_sample    = bus.sample_valid;
      end
      S_ERR:   do_err = 1'b1;
      S_MP:    do_mp  = 1'b1;
      S_MI:    do_mi  = 1'b1;
      S_MD:    do_md  = 1'b1;
      S_OUT:   do_out = 1'b1;
      default: ;
    endcase
  end

  // A clear on the same edge already counts as "no history" for the derivative.
  assign hp_eff   = have_prev_q & ~bus.int_clear;
  assign err_calc = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
  assign de_calc  = $signed({err_calc[W], err_calc}) - $signed({prev_err_q[W], prev_err_q});

  // Shared multiplier operand select
  always_comb begin
    mul_gain = '0;
    mul_opnd = '0;
    case (state_q)
      S_MP: begin
        mul_gain = kp_q;
        mul_opnd = {err_q[W], err_q};
      end
      S_MI: begin
        mul_gain = ki_q;
        mul_opnd = {err_q[W], err_q};
      end
      S_MD: begin
        mul_gain = kd_q;
        mul_opnd = de_q;
      end
      default: ;
    endcase
  end

  // Operands widened to the full product width so the product cannot truncate.
  assign mul_a    = $signed({{(PW-GW){1'b0}}, mul_gain});
  assign mul_b    = $signed({{(PW-W-2){mul_opnd[W+1]}}, mul_opnd});
  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

  // One extra bit on the integral sum so the clamp compare never sees a wrapped value.
  assign int_sum = $signed({integral_q[ACCW-1], integral_q}) + $signed({prod_ext[ACCW-1], prod_ext});

  // Integral anti-windup clamp; a concurrent clear forces the new integral to zero
  always_comb begin
    if (int_sum > LIM_P)      int_clamped = LIM_P[ACCW-1:0];
    else if (int_sum < LIM_N) int_clamped = LIM_N[ACCW-1:0];
    else                      int_clamped = int_sum[ACCW-1:0];
    int_new = bus.int_clear ? '0 : int_clamped;
  end

  assign y = acc_q >>> FRAC;

  // Output saturation into the unsigned actuator range
  always_comb begin
    if (y[ACCW-1])     control_out_d = '0;
    else if (y > Y_MAX) control_out_d = '1;
    else               control_out_d = y[W-1:0];
  end

  // Capture operands and gains on the accept edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      fb_q <= '0;
      kp_q <= '0;
      ki_q <= '0;
      kd_q <= '0;
    end else if (ld_sample) begin
      sp_q <= bus.setpoint;
      fb_q <= bus.feedback;
      kp_q <= bus.kp;
      ki_q <= bus.ki;
      kd_q <= bus.kd;
    end
  end

  // Error and derivative delta
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      de_q  <= '0;
    end else if (do_err) begin
      err_q <= err_calc;
      de_q  <= hp_eff ? de_calc : '0;
    end
  end

  // Accumulator: P term, then integral, then D term
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (do_mp) acc_q <= prod_ext;
    else if (do_mi) acc_q <= acc_q + int_new;
    else if (do_md) acc_q <= acc_q + prod_ext;
  end

  // Integral and derivative history; int_clear wins over any update on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integral_q  <= '0;
      have_prev_q <= 1'b0;
      prev_err_q  <= '0;
    end else begin
      if (bus.int_clear) begin
        integral_q  <= '0;
        have_prev_q <= 1'b0;
      end else begin
        if (do_mi)  integral_q  <= int_clamped;
        if (do_out) have_prev_q <= 1'b1;
      end
      if (do_out) prev_err_q <= err_q;
    end
  end

  // Result register and one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      control_out_q <= '0;
    end else begin
      out_valid_q <= do_out;
      if (do_out) control_out_q <= control_out_d;
    end
  end

  assign bus.sample_ready = sample_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.control_out  = control_out_q;
endmodule
